// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift, rotate, parallel load and clear,
// with a serial bit counter that pulses word_done each time a full word has shifted in.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si_r,
    input  logic             si_l,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic [CNT_W-1:0] cnt,
    output logic             word_done
);

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_ROR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_LOAD  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] q_q,    q_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             done_q, done_d;
    logic             shift_c;

    // Next-state decode; word_done defaults low so it can only be a single-cycle pulse.
    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shift_c = 1'b0;
        if (en) begin
            case (mode)
                MODE_HOLD:  q_d = q_q;
                MODE_SHR: begin
                    q_d     = {si_r, q_q[WIDTH-1:1]};
                    shift_c = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], si_l};
                    shift_c = 1'b1;
                end
                MODE_ROR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_LOAD: begin
                    q_d   = pdin;
                    cnt_d = '0;
                end
                MODE_CLEAR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                default:    q_d = q_q;
            endcase
            if (shift_c) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q         = q_q;
    assign cnt       = cnt_q;
    assign word_done = done_q;
    assign so_r      = q_q[0];
    assign so_l      = q_q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have derived parameter CNT_W, equal to $clog2(WIDTH+1), giving the bit-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port clear_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: operation enable; when it is 0, all registered state holds.
REQ-006 The block SHALL have port mode, input, 3 bits: operation select, decoded per REQ-014.
REQ-007 The block SHALL have port si_r, input, 1 bit: serial input entering at the MSB during right shifts.
REQ-008 The block SHALL have port si_l, input, 1 bit: serial input entering at the LSB during left shifts.
REQ-009 The block SHALL have port pdin, input, WIDTH bits: parallel load data.
REQ-010 The block SHALL have port q, output, WIDTH bits: register contents (registered).
REQ-011 The block SHALL have ports so_r and so_l, outputs, 1 bit each: so_r = q[0] and so_l = q[WIDTH-1], both combinational from q.
REQ-012 The block SHALL have port cnt, output, CNT_W bits: number of serial bits shifted in since the last word boundary, load, clear or reset.
REQ-013 The block SHALL have port word_done, output, 1 bit: registered one-cycle pulse marking that WIDTH serial bits have been shifted in.

Function
REQ-014 Mode decode SHALL apply only when en=1:
- 000: hold.
- 001: shift right, q <= {si_r, q[WIDTH-1:1]}.
- 010: shift left, q <= {q[WIDTH-2:0], si_l}.
- 011: rotate right, q <= {q[0], q[WIDTH-1:1]}.
- 100: rotate left, q <= {q[WIDTH-2:0], q[WIDTH-1]}.
- 101: parallel load, q <= pdin.
- 110: synchronous clear, q <= 0.
- 111: reserved; behaves as hold.
REQ-015 The q update SHALL have one-cycle latency: the values of en, mode, si_r, si_l and pdin sampled at a rising edge SHALL be visible on q immediately after that edge.
REQ-016 cnt SHALL increment by 1 on each enabled shift (modes 001 and 010) only.
REQ-017 On an enabled shift with cnt = WIDTH-1, cnt SHALL wrap to 0 and word_done SHALL be 1 for the following cycle.
REQ-018 word_done SHALL be 0 in every cycle not covered by REQ-017, including cycles with en=0.
REQ-019 Rotate and hold modes (000, 011, 100, 111) SHALL leave cnt unchanged.
REQ-020 Parallel load (101) and synchronous clear (110) SHALL set cnt to 0 and leave word_done at 0.
REQ-021 Mixing shift directions SHALL be legal; every enabled shift in either direction SHALL count toward the same cnt.
REQ-022 cnt SHALL never exceed WIDTH-1 when observed.
REQ-023 With en=0, q and cnt SHALL hold regardless of mode, serial inputs or pdin.
REQ-024 Changes on serial inputs or pdin between clock edges SHALL have no effect on registered state.

Reset
REQ-025 When clear_n = 0, the block SHALL immediately and asynchronously force q = 0, cnt = 0 and word_done = 0, independent of clk.
REQ-026 As a consequence of REQ-025, so_r and so_l SHALL read 0 while clear_n = 0.
REQ-027 Reset assertion during an operation SHALL abort it, and no partial word SHALL be retained.
REQ-028 After clear_n deasserts, the first rising edge with en=1 SHALL perform the selected operation normally from the all-zero state.

Verification
REQ-029 The bench SHALL cover, with WIDTH=4: from reset, en=1, mode=001, si_r=1,0,0,0 over 4 edges -> q=1000, 0100, 0010, 0001; cnt=1, 2, 3, 0; word_done=1 only in the cycle after the 4th edge; so_r=1 at the end.
REQ-030 The bench SHALL cover, with WIDTH=4: mode=101, pdin=1011, then mode=100 for 2 edges -> q=1011, 0111, 1110; cnt stays 0; word_done stays 0.
REQ-031 The bench SHALL cover, with WIDTH=4: from reset, mode=010, si_l=1 for 3 edges, then en=0 for 2 edges with mode=101 and pdin=1111 -> q=0001, 0011, 0111, then q holds at 0111 with cnt=3.
REQ-032 The bench SHALL cover, with WIDTH=4: after 2 right shifts (cnt=2), drive clear_n low between clock edges -> q=0, cnt=0 and word_done=0 before the next edge; after release, 4 further shifts produce word_done exactly once.
REQ-033 The bench SHALL cover, with WIDTH=4: with q=1011, mode=111 with en=1 -> q holds at 1011; then mode=110 with en=1 -> q=0000 and cnt=0.
REQ-034 The bench SHALL cover, with WIDTH=4: alternating mode 001 and mode 010 for 4 edges -> cnt wraps to 0 and word_done pulses once after the 4th edge.
